// File: rtl/ysyx_23060221_pkg.sv
// ---------------------------------------------------------------------------
// ysyx_23060221_pkg
// Purpose : definitions shared by the instruction fetch unit, its bus
//           interface and anything else that needs the IFU FSM encoding.
// Contents: ifu_state_e         - fetch FSM states
//           FAULT_INST_DEFAULT  - instruction word used on a fetch fault (ebreak)
//           RESP_OKAY           - read response code meaning success
// ---------------------------------------------------------------------------
package ysyx_23060221_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    AR   = 2'd1,
    R    = 2'd2,
    OUT  = 2'd3
  } ifu_state_e;

  localparam logic [31:0] FAULT_INST_DEFAULT = 32'h00100073;
  localparam logic [1:0]  RESP_OKAY          = 2'b00;

endpackage

// File: rtl/ysyx_23060221_ifu_if.sv
// ---------------------------------------------------------------------------
// ysyx_23060221_ifu_if
// Purpose : read-only memory bus between the fetch unit and instruction memory
//           (address channel + read data channel).
// Signals : araddr[31:0] - read address          (master -> slave)
//           arvalid      - read address valid    (master -> slave)
//           arready      - address accepted      (slave  -> master)
//           rdata[31:0]  - read data             (slave  -> master)
//           rresp[1:0]   - read response         (slave  -> master)
//           rvalid       - read data valid       (slave  -> master)
//           rready       - read data accepted    (master -> slave)
// Modports: master (fetch unit), slave (memory model)
// ---------------------------------------------------------------------------
interface ysyx_23060221_ifu_if;

  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  modport master (
    output araddr, arvalid, rready,
    input  arready, rdata, rresp, rvalid
  );

  modport slave (
    input  araddr, arvalid, rready,
    output arready, rdata, rresp, rvalid
  );

endinterface

// File: rtl/ysyx_23060221_ifu.sv
// ---------------------------------------------------------------------------
// ysyx_23060221_ifu
// Purpose : instruction fetch unit. Accepts a PC from writeback, reads one
//           instruction word over the memory bus and hands it to the decoder.
//           Misaligned PCs, error responses and read timeouts all produce
//           FAULT_INST with fetch_err set. At most one fetch is in flight.
// Params  : TIMEOUT    - max R-state cycles waited for rvalid
//           FAULT_INST - instruction word presented on any fetch fault
// Ports   : clk, rst          - clock, synchronous active-high reset
//           pc, WBU_valid      - next PC offered by writeback
//           IFU_ready          - PC accepted (IDLE only)
//           mem (master)       - instruction memory read bus
//           inst, inst_pc      - fetched word and its PC
//           fetch_err          - inst is FAULT_INST because of a fault
//           IFU_valid          - inst/inst_pc/fetch_err valid for decoder
//           IDU_ready          - decoder takes the instruction
// ---------------------------------------------------------------------------
module ysyx_23060221_ifu
  import ysyx_23060221_pkg::*;
#(
  parameter int          TIMEOUT    = 256,
  parameter logic [31:0] FAULT_INST = FAULT_INST_DEFAULT
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [31:0]                 pc,
  input  logic                        WBU_valid,
  output logic                        IFU_ready,
  ysyx_23060221_ifu_if.master         mem,
  output logic [31:0]                 inst,
  output logic [31:0]                 inst_pc,
  output logic                        fetch_err,
  output logic                        IFU_valid,
  input  logic                        IDU_ready
);

  // A TIMEOUT of 1 would give a zero-width counter; keep at least one bit.
  localparam int                 CNT_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0]   CNT_MAX = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0]   CNT_ONE = CNT_W'(1);

  ifu_state_e       state_q, state_d;
  logic [31:0]      araddr_q, araddr_d;
  logic [31:0]      inst_q, inst_d;
  logic [31:0]      inst_pc_q, inst_pc_d;
  logic             fetch_err_q, fetch_err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      araddr_q    <= '0;
      inst_q      <= '0;
      inst_pc_q   <= '0;
      fetch_err_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      araddr_q    <= araddr_d;
      inst_q      <= inst_d;
      inst_pc_q   <= inst_pc_d;
      fetch_err_q <= fetch_err_d;
      cnt_q       <= cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    araddr_d    = araddr_q;
    inst_d      = inst_q;
    inst_pc_d   = inst_pc_q;
    fetch_err_d = fetch_err_q;
    cnt_d       = cnt_q;

    case (state_q)
      IDLE: begin
        // IFU_ready is high in IDLE, so WBU_valid alone completes the handshake.
        if (WBU_valid) begin
          araddr_d  = pc;
          inst_pc_d = pc;
          if (pc[1:0] != 2'b00) begin
            inst_d      = FAULT_INST;
            fetch_err_d = 1'b1;
            state_d     = OUT;
          end else begin
            state_d = AR;
          end
        end
      end
      AR: begin
        if (mem.arready) begin
          cnt_d   = '0;
          state_d = R;
        end
      end
      R: begin
        // rvalid wins over a timeout expiring in the same cycle.
        if (mem.rvalid) begin
          if (mem.rresp == RESP_OKAY) begin
            inst_d      = mem.rdata;
            fetch_err_d = 1'b0;
          end else begin
            inst_d      = FAULT_INST;
            fetch_err_d = 1'b1;
          end
          state_d = OUT;
        end else if (cnt_q == CNT_MAX) begin
          inst_d      = FAULT_INST;
          fetch_err_d = 1'b1;
          state_d     = OUT;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      OUT: begin
        if (IDU_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs depend only on the state register.
  assign IFU_ready   = (state_q == IDLE);
  assign mem.arvalid = (state_q == AR);
  assign mem.rready  = (state_q == R);
  assign IFU_valid   = (state_q == OUT);

  assign mem.araddr  = araddr_q;
  assign inst        = inst_q;
  assign inst_pc     = inst_pc_q;
  assign fetch_err   = fetch_err_q;

endmodule

// File: tb/tb_ysyx_23060221_ifu.sv
// ---------------------------------------------------------------------------
// tb_ysyx_23060221_ifu
// Purpose : self-checking bench for the instruction fetch unit. Each fetch is
//           described by its PC, bus delays and response; a timeline of
//           expected handshake levels is checked every cycle.
// ---------------------------------------------------------------------------
module tb_ysyx_23060221_ifu;

  localparam int          TIMEOUT = 4;
  localparam logic [31:0] EBREAK  = 32'h00100073;

  typedef struct {
    logic [31:0] pc;
    int          da;
    int          dr;
    logic [1:0]  rresp;
    logic [31:0] rdata;
    int          di;
    logic [31:0] exp_inst;
    logic        exp_err;
    int          exp_lat;
  } fetch_vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc;
  logic        WBU_valid;
  logic        IFU_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        fetch_err;
  logic        IFU_valid;
  logic        IDU_ready;

  int nCompared   = 0;
  int nMismatched = 0;

  fetch_vec_t vecs [9];

  ysyx_23060221_ifu_if mem_if ();

  ysyx_23060221_ifu #(
    .TIMEOUT   (TIMEOUT),
    .FAULT_INST(EBREAK)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .pc       (pc),
    .WBU_valid(WBU_valid),
    .IFU_ready(IFU_ready),
    .mem      (mem_if),
    .inst     (inst),
    .inst_pc  (inst_pc),
    .fetch_err(fetch_err),
    .IFU_valid(IFU_valid),
    .IDU_ready(IDU_ready)
  );

  // 10 ns clock period.
  always #5 clk = ~clk;

  // Advance one cycle and sample 1 ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Random values on inputs the fetch unit must ignore in the current phase.
  task automatic driveNoise();
    mem_if.arready = 1'($urandom_range(0, 1));
    mem_if.rvalid  = 1'($urandom_range(0, 1));
    mem_if.rdata   = $urandom;
    mem_if.rresp   = 2'($urandom_range(0, 3));
    IDU_ready      = 1'($urandom_range(0, 1));
  endtask

  // Reference behaviour of one fetch, written from the block's rules:
  // misaligned -> immediate fault; otherwise one AR cycle per arready delay
  // plus one, then R until rvalid or the TIMEOUT-th R cycle.
  function automatic fetch_vec_t refModel(input logic [31:0] fpc, input int da, input int dr,
                                          input logic [1:0] rresp, input logic [31:0] rdata,
                                          input int di);
    fetch_vec_t v;
    int rCycles;
    v.pc    = fpc;
    v.da    = da;
    v.dr    = dr;
    v.rresp = rresp;
    v.rdata = rdata;
    v.di    = di;
    rCycles = ((dr < TIMEOUT) ? dr : TIMEOUT - 1) + 1;
    v.exp_err  = (fpc[1:0] != 2'b00) || (dr >= TIMEOUT) || (rresp != 2'b00);
    v.exp_inst = v.exp_err ? EBREAK : rdata;
    v.exp_lat  = (fpc[1:0] != 2'b00) ? 1 : 1 + (da + 1) + rCycles;
    return v;
  endfunction

  // Runs one fetch starting from an IDLE sample point. Cycle c counts edges
  // since the PC was offered; every cycle the handshake levels are compared
  // with the timeline implied by the vector.
  task automatic applyStimulus(input fetch_vec_t v);
    bit aligned;
    int rStart;
    int rHit;
    int last;
    logic [3:0] expCtrl;
    aligned = (v.pc[1:0] == 2'b00);
    rStart  = 2 + v.da;
    rHit    = rStart + v.dr;
    last    = v.exp_lat + v.di + 1;
    driveNoise();
    pc        = v.pc;
    WBU_valid = 1'b1;
    for (int c = 1; c <= last; c++) begin
      tick();
      expCtrl = {c == last,
                 aligned && c <= 1 + v.da,
                 aligned && c >= rStart && c < v.exp_lat,
                 c >= v.exp_lat && c < last};
      checkOutput("ctrl{IFU_ready,arvalid,rready,IFU_valid}",
                  {28'd0, IFU_ready, mem_if.arvalid, mem_if.rready, IFU_valid}, {28'd0, expCtrl});
      if (aligned && c <= 1 + v.da) checkOutput("araddr", mem_if.araddr, v.pc);
      if (c >= v.exp_lat && c < last) begin
        checkOutput("inst", inst, v.exp_inst);
        checkOutput("inst_pc", inst_pc, v.pc);
        checkOutput("fetch_err", {31'd0, fetch_err}, {31'd0, v.exp_err});
      end
      if (c < last) begin
        driveNoise();
        pc        = $urandom;
        WBU_valid = 1'b1;
        if (aligned && c <= 1 + v.da) mem_if.arready = (c == 1 + v.da);
        if (aligned && c >= rStart && c < v.exp_lat) begin
          mem_if.rvalid = (c == rHit);
          mem_if.rdata  = v.rdata;
          mem_if.rresp  = v.rresp;
        end
        if (c >= v.exp_lat) IDU_ready = (c == v.exp_lat + v.di);
      end
    end
    WBU_valid = 1'b0;
  endtask

  initial begin
    fetch_vec_t rv;
    logic [31:0] rpc;
    logic [1:0]  rresp;

    //            pc            da  dr  rresp  rdata          di  inst          err   lat
    vecs[0] = '{32'h20000000, 0,  0,  2'b00, 32'h00000413, 0, 32'h00000413, 1'b0, 3};
    vecs[1] = '{32'h20000002, 0,  0,  2'b00, 32'h11111111, 0, EBREAK,       1'b1, 1};
    vecs[2] = '{32'h20000004, 0,  0,  2'b10, 32'hdeadbeef, 0, EBREAK,       1'b1, 3};
    vecs[3] = '{32'h20000008, 5,  0,  2'b00, 32'h12345678, 3, 32'h12345678, 1'b0, 8};
    vecs[4] = '{32'h2000000c, 0, 10,  2'b00, 32'h22222222, 0, EBREAK,       1'b1, 6};
    vecs[5] = '{32'h20000010, 1,  3,  2'b00, 32'hcafef00d, 1, 32'hcafef00d, 1'b0, 7};
    vecs[6] = '{32'h20000014, 0,  4,  2'b00, 32'h33333333, 2, EBREAK,       1'b1, 6};
    vecs[7] = '{32'h20000001, 0,  0,  2'b00, 32'h44444444, 2, EBREAK,       1'b1, 1};
    vecs[8] = '{32'h80000020, 2,  1,  2'b01, 32'h55555555, 1, EBREAK,       1'b1, 6};

    // Reset with writeback already offering a PC: nothing may be accepted.
    rst       = 1'b1;
    pc        = 32'h20000000;
    WBU_valid = 1'b1;
    driveNoise();
    tick();
    tick();
    checkOutput("reset ctrl", {28'd0, IFU_ready, mem_if.arvalid, mem_if.rready, IFU_valid}, 32'h8);
    checkOutput("reset araddr", mem_if.araddr, 32'h0);
    checkOutput("reset inst", inst, 32'h0);
    checkOutput("reset inst_pc", inst_pc, 32'h0);
    checkOutput("reset fetch_err", {31'd0, fetch_err}, 32'h0);
    rst = 1'b0;

    for (int i = 0; i < 9; i++) applyStimulus(vecs[i]);

    // Reset while waiting in R abandons the fetch.
    driveNoise();
    pc             = 32'h20000020;
    WBU_valid      = 1'b1;
    mem_if.arready = 1'b1;
    mem_if.rvalid  = 1'b0;
    tick();
    checkOutput("rstR arvalid", {31'd0, mem_if.arvalid}, 32'h1);
    mem_if.rvalid = 1'b0;
    WBU_valid     = 1'b0;
    tick();
    checkOutput("rstR rready", {31'd0, mem_if.rready}, 32'h1);
    rst = 1'b1;
    tick();
    checkOutput("rstR ctrl after reset", {28'd0, IFU_ready, mem_if.arvalid, mem_if.rready, IFU_valid}, 32'h8);
    checkOutput("rstR araddr after reset", mem_if.araddr, 32'h0);
    rst = 1'b0;
    applyStimulus(vecs[0]);

    // Randomised fetches checked against the reference model.
    for (int i = 0; i < 40; i++) begin
      rpc = $urandom;
      if ($urandom_range(0, 3) != 0) rpc[1:0] = 2'b00;
      rresp = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      rv = refModel(rpc, $urandom_range(0, 3), $urandom_range(0, 6), rresp, $urandom,
                    $urandom_range(0, 3));
      applyStimulus(rv);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/ysyx_23060221_ifu.md
YSYX_23060221_IFU -- requirements
Module: ysyx_23060221_Ifu

Interface
REQ-001 SHALL have parameter TIMEOUT, default 256, meaning the maximum number of R-state cycles waited for rvalid before a fetch fault.
REQ-002 SHALL have parameter FAULT_INST, default 32'h00100073 (ebreak), meaning the instruction word presented on any fetch fault.
REQ-003 SHALL have port clk  in  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  in  1  reset, synchronous and active-high.
REQ-005 SHALL have port pc  in  32  next PC from the writeback stage, valid when WBU_valid=1.
REQ-006 SHALL have port WBU_valid  in  1  writeback stage offers a PC.
REQ-007 SHALL have port IFU_ready  out  1  block accepts a PC.
REQ-008 SHALL have port araddr  out  32  read address, equal to the latched PC.
REQ-009 SHALL have port arvalid  out  1  read address valid.
REQ-010 SHALL have port arready  in  1  memory accepts the address.
REQ-011 SHALL have port rdata  in  32  read data.
REQ-012 SHALL have port rresp  in  2  read response; 2'b00 means OKAY.
REQ-013 SHALL have port rvalid  in  1  read data valid.
REQ-014 SHALL have port rready  out  1  block accepts read data.
REQ-015 SHALL have port inst  out  32  fetched instruction.
REQ-016 SHALL have port inst_pc  out  32  PC of inst.
REQ-017 SHALL have port fetch_err  out  1  inst is FAULT_INST because of a fault.
REQ-018 SHALL have port IFU_valid  out  1  inst, inst_pc and fetch_err are valid for the decoder.
REQ-019 SHALL have port IDU_ready  in  1  decoder accepts the instruction.

Function
REQ-020 SHALL implement a four-state FSM: IDLE, AR, R, OUT. IFU_ready=1 only in IDLE, arvalid=1 only in AR, rready=1 only in R, IFU_valid=1 only in OUT; all four outputs are decoded only from the state register.
REQ-021 IDLE: on WBU_valid&IFU_ready, SHALL latch pc into araddr and inst_pc. If pc[1:0]!=0, go to OUT with inst=FAULT_INST and fetch_err=1; otherwise go to AR.
REQ-022 AR: araddr SHALL stay stable; on arready, go to R and clear the timeout counter.
REQ-023 R: on rvalid, SHALL load inst=rdata and fetch_err=0 if rresp==0, otherwise inst=FAULT_INST and fetch_err=1; then go to OUT.
REQ-024 R without rvalid: SHALL increment the counter each cycle; when the counter reaches TIMEOUT-1, go to OUT with inst=FAULT_INST and fetch_err=1. An rvalid in that same cycle takes priority.
REQ-025 OUT: inst, inst_pc and fetch_err SHALL stay stable; on IDU_ready, go to IDLE.
REQ-026 Minimum latency SHALL be: accept in cycle N, arvalid in N+1, rready in N+2, IFU_valid in N+3 when arready and rvalid each arrive on their first cycle.
REQ-027 rvalid and arready outside R and AR respectively SHALL be ignored with no state change.
REQ-028 The timeout counter SHALL be $clog2(TIMEOUT) bits wide and saturate, never wrap.
REQ-029 A new PC SHALL NOT be accepted until the current instruction has handed off, so at most one fetch is outstanding.

Reset
REQ-030 While rst=1, the block SHALL go to IDLE and set IFU_ready=1, arvalid=0, rready=0, IFU_valid=0, araddr=0, inst=0, inst_pc=0, fetch_err=0, counter=0.
REQ-031 A reset in AR, R or OUT SHALL abandon the transaction, with arvalid and rready low in the cycle after reset is sampled.
REQ-032 The first post-reset fetch SHALL use whatever pc the writeback stage presents; WBU_valid=1 with pc=32'h20000000 is the normal case.

Structure
REQ-033 The state enum, FAULT_INST default and RESP_OKAY constant SHALL live in the shared package ysyx_23060221_pkg.
REQ-034 The block SHALL have no sub-modules; FSM, counter and registers are implemented inline.

Verification
REQ-035 The bench SHALL apply reset, WBU_valid=1, pc=32'h20000000, arready=1 immediately, rvalid next cycle with rdata=32'h00000413, and check IFU_valid at accept+3 with inst=32'h00000413, inst_pc=32'h20000000, fetch_err=0.
REQ-036 The bench SHALL present pc=32'h20000002 and check that the FSM goes IDLE->OUT with no arvalid, inst=32'h00100073 and fetch_err=1.
REQ-037 The bench SHALL return rresp=2'b10 and rdata=32'hdeadbeef, and check inst=32'h00100073 and fetch_err=1.
REQ-038 The bench SHALL hold arready low 5 cycles and IDU_ready low 3 cycles, and check araddr and inst stable throughout with IFU_ready=0 despite WBU_valid=1.
REQ-039 With TIMEOUT=4 and no rvalid, the bench SHALL check fetch_err=1 exactly 4 R cycles after address acceptance.
REQ-040 The bench SHALL assert rst in R and check arvalid=0, rready=0, IFU_ready=1 the next cycle, then a fresh fetch that completes correctly.
